rs232tx: RTL

Serial transmitter at the far end of the `rs232out_w` / `rs232out_d` / `rs232out_busy` handshake driven by the memory-mapped rs232 peripheral. It accepts one byte per write strobe and serialises it onto `txd` as 8N1 asynchronous serial: one start bit, 8 data bits LSB first, and a configurable number of stop bits. It sits between the peripheral and the FPGA pin. An optional 4-entry FIFO decouples the peripheral's polling loop from the line rate.

---
 rtl/rs232tx.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/rs232tx.sv
// 8N1 serial transmitter fed by the rs232out_w/_d/_busy handshake.
// Define RS232TX_FIFO_EN to put a 4-entry FIFO in front of the shifter.
module rs232tx #(
  parameter int clk_freq  = 25000000,
  parameter int bps       = 115200,
  parameter int stop_bits = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rs232out_w,
  input  logic [7:0] rs232out_d,
  output logic       rs232out_busy,
  output logic       txd
);
  localparam int PERIOD = clk_freq / bps;
  localparam int BW     = (PERIOD < 2) ? 1 : $clog2(PERIOD);
  localparam logic [BW-1:0] BAUD_LOAD = BW'(PERIOD - 1);
  localparam logic          STOP_LOAD = (stop_bits == 2);

  if (PERIOD < 2) begin : g_bad_period
    $error("rs232tx: clk_freq/bps must be at least 2");
  end
  if (stop_bits != 1 && stop_bits != 2) begin : g_bad_stop
    $error("rs232tx: stop_bits must be 1 or 2");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [BW-1:0]   baud;
  logic [2:0]      bit_cnt;
  logic            stop_cnt;
  logic [7:0]      shift;

  logic            accept;
  logic            avail;
  logic [7:0]      head;
  logic            stop_end;
  logic            load;
  logic            busy_nxt;

  assign accept   = rs232out_w & ~rs232out_busy;
  assign stop_end = (state == STOP) && (baud == '0) && !stop_cnt;
  // A byte is consumed either from idle or straight out of the last stop bit.
  assign load     = avail & ((state == IDLE) | stop_end);

`ifdef RS232TX_FIFO_EN
  logic [7:0] mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count, count_nxt;

  assign avail     = (count != 3'd0);
  assign head      = mem[rd_ptr];
  assign count_nxt = count + {2'b0, accept} - {2'b0, load};
  assign busy_nxt  = (count_nxt == 3'd4);

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= rs232out_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 2'd1;
      if (load)   rd_ptr <= rd_ptr + 2'd1;
      count <= count_nxt;
    end
  end
`else
  // Without a FIFO the write itself is the byte; busy blocks it outside IDLE.
  assign avail    = accept;
  assign head     = rs232out_d;
  assign busy_nxt = load | (rs232out_busy & ~stop_end);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rs232out_busy <= 1'b0;
    else      rs232out_busy <= busy_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      txd      <= 1'b1;
      baud     <= '0;
      bit_cnt  <= 3'd0;
      stop_cnt <= 1'b0;
      shift    <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (load) begin
            shift   <= head;
            bit_cnt <= 3'd0;
            baud    <= BAUD_LOAD;
            txd     <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (baud == '0) begin
            baud  <= BAUD_LOAD;
            txd   <= shift[0];
            state <= DATA;
          end else begin
            baud <= baud - 1'b1;
          end
        end
        DATA: begin
          if (baud == '0) begin
            baud    <= BAUD_LOAD;
            shift   <= shift >> 1;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              txd      <= 1'b1;
              stop_cnt <= STOP_LOAD;
              state    <= STOP;
            end else begin
              txd <= shift[1];
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
        STOP: begin
          if (baud == '0) begin
            baud <= BAUD_LOAD;
            if (stop_cnt) begin
              stop_cnt <= 1'b0;
            end else if (load) begin
              shift   <= head;
              bit_cnt <= 3'd0;
              txd     <= 1'b0;
              state   <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
